// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, driving a combinational
// instruction memory and registering the fetched word plus its PC into IF/ID.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_addr / imem_instr     combinational instruction-memory address / data
//   stall                      hold PC and IF/ID register
//   redirect_valid/_target     execute-stage flush to a new PC (highest priority)
//   jump_valid / jump_addr     decode-stage unconditional jump
//   if_valid/if_instr/if_pc    IF/ID register outputs
//   if_pc_next                 if_pc + PC_INCREMENT_VAL
//   halted                     fetch stopped on a HALT word
module fetch_unit #(
   parameter int ADDRESS_WIDTH     = 8,
   parameter int INSTRUCTION_WIDTH = 16,
   parameter int OPCODE_WIDTH      = 4,
   parameter int JUMP_ADDR_WIDTH   = 12,
   parameter int PC_INCREMENT_VAL  = 2,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = 8'h00,
   parameter logic [OPCODE_WIDTH-1:0]  HALT_OPCODE = 4'hF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [ADDRESS_WIDTH-1:0]     imem_addr,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
   input  logic                         stall,
   input  logic                         redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0]     redirect_target,
   input  logic                         jump_valid,
   input  logic [JUMP_ADDR_WIDTH-1:0]   jump_addr,
   output logic                         if_valid,
   output logic [INSTRUCTION_WIDTH-1:0] if_instr,
   output logic [ADDRESS_WIDTH-1:0]     if_pc,
   output logic [ADDRESS_WIDTH-1:0]     if_pc_next,
   output logic                         halted
);

   localparam int AW = ADDRESS_WIDTH;
   localparam int IW = INSTRUCTION_WIDTH;
   localparam int OW = OPCODE_WIDTH;
   localparam int JW = JUMP_ADDR_WIDTH;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]    r_state;
   logic [AW-1:0] r_pc;
   logic          r_if_valid;
   logic [IW-1:0] r_if_instr;
   logic [AW-1:0] r_if_pc;

   logic          w_is_halt;
   logic [AW-1:0] w_redir_pc;
   logic [AW-1:0] w_jump_pc;
   logic [AW-1:0] w_pc_inc;
   logic          w_unused;

   // Targets are forced even so a fetch can never be misaligned.
   assign w_redir_pc = {redirect_target[AW-1:1], 1'b0};
   assign w_jump_pc  = {jump_addr[AW-1:1], 1'b0};
   assign w_pc_inc   = r_pc + AW'(PC_INCREMENT_VAL);
   assign w_is_halt  = (imem_instr[IW-1 -: OW] == HALT_OPCODE);
   assign w_unused   = ^{jump_addr[JW-1:AW], jump_addr[0],
                         redirect_target[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_PC;
         r_if_valid <= 1'b0;
         r_if_instr <= '0;
         r_if_pc    <= '0;
      end else begin
         unique case (r_state)
            S_BOOT: r_state <= S_RUN;
            S_RUN: begin
               if (redirect_valid) begin
                  r_pc       <= w_redir_pc;
                  r_if_valid <= 1'b0;
               end else if (jump_valid) begin
                  r_pc       <= w_jump_pc;
                  r_if_valid <= 1'b0;
               end else if (!stall) begin
                  r_if_instr <= imem_instr;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  // HALT word is captured but the PC stays on it.
                  if (w_is_halt) r_state <= S_HALT;
                  else           r_pc    <= w_pc_inc;
               end
            end
            S_HALT: begin
               if (redirect_valid) begin
                  r_pc       <= w_redir_pc;
                  r_if_valid <= 1'b0;
                  r_state    <= S_RUN;
               end else if (!stall) begin
                  // HALT word consumed by decode; nothing more to offer.
                  r_if_valid <= 1'b0;
               end
            end
            default: r_state <= S_BOOT;
         endcase
      end
   end

   assign imem_addr  = r_pc;
   assign if_valid   = r_if_valid;
   assign if_instr   = r_if_instr;
   assign if_pc      = r_if_pc;
   assign if_pc_next = r_if_pc + AW'(PC_INCREMENT_VAL);
   assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a
// combinational instruction-memory model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  imem_addr;
   logic [15:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [7:0]  redirect_target;
   logic        jump_valid;
   logic [11:0] jump_addr;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [7:0]  if_pc;
   logic [7:0]  if_pc_next;
   logic        halted;

   int n_cmp;
   int n_err;

   logic [15:0] mem [0:127];

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .jump_valid      (jump_valid),
      .jump_addr       (jump_addr),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_pc_next      (if_pc_next),
      .halted          (halted)
   );

   assign imem_instr = mem[imem_addr[7:1]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      stall = 0; redirect_valid = 0; jump_valid = 0;
      redirect_target = 8'h00; jump_addr = 12'h000;
   endtask

   task automatic test_reset();
      rst_n = 0; idle();
      repeat (2) step();
      chk("rst_valid", 16'(if_valid), 16'h0);
      chk("rst_instr", if_instr, 16'h0000);
      chk("rst_pc", 16'(if_pc), 16'h00);
      chk("rst_halted", 16'(halted), 16'h0);
      chk("rst_addr", 16'(imem_addr), 16'h00);
      #3 rst_n = 1;
      step();
      chk("boot_valid", 16'(if_valid), 16'h0);
      chk("boot_addr", 16'(imem_addr), 16'h00);
      step();
      chk("f0_instr", if_instr, 16'h1111);
      chk("f0_pc", 16'(if_pc), 16'h00);
      chk("f0_valid", 16'(if_valid), 16'h1);
      chk("f0_pcnext", 16'(if_pc_next), 16'h02);
      step();
      chk("f1_instr", if_instr, 16'h2222);
      chk("f1_pc", 16'(if_pc), 16'h02);
      step();
      chk("f2_instr", if_instr, 16'h3333);
      chk("f2_pc", 16'(if_pc), 16'h04);
   endtask

   task automatic test_stall();
      redirect_valid = 1; redirect_target = 8'h00;
      step();
      idle();
      chk("st_bubble", 16'(if_valid), 16'h0);
      step();
      chk("st_f0", if_instr, 16'h1111);
      step();
      chk("st_f1", if_instr, 16'h2222);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_hold_instr", if_instr, 16'h2222);
         chk("st_hold_pc", 16'(if_pc), 16'h02);
         chk("st_hold_addr", 16'(imem_addr), 16'h04);
         chk("st_hold_valid", 16'(if_valid), 16'h1);
      end
      stall = 0;
      step();
      chk("st_rel_instr", if_instr, 16'h3333);
      chk("st_rel_pc", 16'(if_pc), 16'h04);
      step();
      chk("st_next_instr", if_instr, 16'h4444);
   endtask

   task automatic test_redirect_priority();
      redirect_valid = 1; redirect_target = 8'h21;
      jump_valid = 1; jump_addr = 12'h0A6; stall = 1;
      step();
      idle();
      chk("rd_addr", 16'(imem_addr), 16'h20);
      chk("rd_bubble", 16'(if_valid), 16'h0);
      step();
      chk("rd_pc", 16'(if_pc), 16'h20);
      chk("rd_instr", if_instr, 16'hA020);
      chk("rd_valid", 16'(if_valid), 16'h1);
   endtask

   task automatic test_jump();
      jump_valid = 1; jump_addr = 12'hF13; stall = 1;
      step();
      idle();
      chk("jp_addr", 16'(imem_addr), 16'h12);
      chk("jp_bubble", 16'(if_valid), 16'h0);
      step();
      chk("jp_pc", 16'(if_pc), 16'h12);
      chk("jp_instr", if_instr, 16'hA012);
   endtask

   task automatic test_wrap();
      redirect_valid = 1; redirect_target = 8'hFC;
      step();
      idle();
      step();
      chk("wr_pc0", 16'(if_pc), 16'hFC);
      chk("wr_instr0", if_instr, 16'hA0FC);
      step();
      chk("wr_pc1", 16'(if_pc), 16'hFE);
      chk("wr_pcnext", 16'(if_pc_next), 16'h00);
      step();
      chk("wr_pc2", 16'(if_pc), 16'h00);
      chk("wr_instr2", if_instr, 16'h1111);
      chk("wr_addr", 16'(imem_addr), 16'h02);
   endtask

   task automatic test_halt();
      redirect_valid = 1; redirect_target = 8'h08;
      step();
      idle();
      chk("ht_pre_halted", 16'(halted), 16'h0);
      stall = 1;
      step();
      chk("ht_stall_nofetch", 16'(if_valid), 16'h0);
      stall = 0;
      step();
      chk("ht_instr", if_instr, 16'hF000);
      chk("ht_valid", 16'(if_valid), 16'h1);
      chk("ht_pc", 16'(if_pc), 16'h08);
      chk("ht_halted", 16'(halted), 16'h1);
      chk("ht_addr", 16'(imem_addr), 16'h08);
      stall = 1;
      step();
      chk("ht_keep_valid", 16'(if_valid), 16'h1);
      stall = 0;
      step();
      chk("ht_drop_valid", 16'(if_valid), 16'h0);
      chk("ht_still_halted", 16'(halted), 16'h1);
      jump_valid = 1; jump_addr = 12'h040;
      repeat (2) step();
      idle();
      chk("ht_jump_ign", 16'(imem_addr), 16'h08);
      chk("ht_jump_valid", 16'(if_valid), 16'h0);
      chk("ht_jump_halted", 16'(halted), 16'h1);
      redirect_valid = 1; redirect_target = 8'h10;
      step();
      idle();
      chk("ht_res_halted", 16'(halted), 16'h0);
      chk("ht_res_addr", 16'(imem_addr), 16'h10);
      chk("ht_res_bubble", 16'(if_valid), 16'h0);
      step();
      chk("ht_res_pc", 16'(if_pc), 16'h10);
      chk("ht_res_instr", if_instr, 16'hA010);
   endtask

   task automatic test_async_reset();
      step();
      #3 rst_n = 0;
      #1;
      chk("ar_valid", 16'(if_valid), 16'h0);
      chk("ar_instr", if_instr, 16'h0000);
      chk("ar_pc", 16'(if_pc), 16'h00);
      chk("ar_addr", 16'(imem_addr), 16'h00);
      #2 rst_n = 1;
      step();
      chk("ar_boot_valid", 16'(if_valid), 16'h0);
      step();
      chk("ar_f0_instr", if_instr, 16'h1111);
      chk("ar_f0_pc", 16'(if_pc), 16'h00);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 128; i++) mem[i] = 16'hA000 | 16'(i * 2);
      mem[0] = 16'h1111;
      mem[1] = 16'h2222;
      mem[2] = 16'h3333;
      mem[3] = 16'h4444;
      mem[4] = 16'hF000;
      test_reset();
      test_stall();
      test_redirect_priority();
      test_jump();
      test_wrap();
      test_halt();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
